// File: rtl/pwm_demodulator_pkg.sv
// Shared definitions for the PWM link: FSM state encodings and the default
// step/symbol constants used by both the transmit-side modulator and this
// receive-side demodulator.
//
// Contents:
//   state_e              - demodulator FSM states
//   DEF_CLKS_PER_STEP    - default clk cycles per PWM step
//   DEF_STEPS_PER_SYMBOL - default PWM steps per symbol window
//   DEF_SAMPLE_BITS      - default recovered sample width
//   sat_limit()          - clamps a count to the largest value of a given width
package pwm_demodulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    localparam int DEF_CLKS_PER_STEP    = 1;
    localparam int DEF_STEPS_PER_SYMBOL = 128;
    localparam int DEF_SAMPLE_BITS      = 8;

    function automatic int sat_limit(input int value, input int bits);
        int max_val;
        max_val = (1 << bits) - 1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/pwm_demodulator_counter.sv
// Step-tick timer: down-counter with terminal-count compare. While clr is
// low it emits a one-cycle tick whenever the count sits at zero and then
// reloads MAX_COUNT-1, giving one tick every MAX_COUNT cycles. Holding clr
// high parks the count at zero so the first cycle after clr drops ticks.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - hold counter at zero (no ticks while high)
//   tick - one-cycle step tick
module pwm_demodulator_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(MAX_COUNT - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick = !clr && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_demodulator.sv
// PWM demodulator: synchronizes an asynchronous PWM line, locks its symbol
// window to the first rising edge, then free-runs, counting high steps per
// window and writing the saturated duty count to a downstream FIFO.
//
// Ports:
//   clk       - clock, all logic on posedge
//   rst       - synchronous active-high reset
//   enable    - run; low aborts the current symbol and returns to IDLE
//   pwm_in    - asynchronous PWM input
//   full      - downstream FIFO full, looked at only in the symbol-end cycle
//   write     - one-cycle FIFO write strobe
//   sample    - recovered duty value, valid with write
//   locked    - high while in MEASURE
//   overflow  - sticky: a sample was dropped because full was set
//   symb_tick - one-cycle pulse after each completed symbol
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | stopped, waiting for enable
// ST_ACQUIRE | waiting for the first rising edge of pwm_s to align windows
// ST_MEASURE | free-running step ticks, counting duty per symbol window
module pwm_demodulator
    import pwm_demodulator_pkg::*;
#(
    parameter int CLKS_PER_STEP    = DEF_CLKS_PER_STEP,
    parameter int STEPS_PER_SYMBOL = DEF_STEPS_PER_SYMBOL,
    parameter int SAMPLE_BITS      = DEF_SAMPLE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pwm_in,
    input  logic                   full,
    output logic                   write,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   locked,
    output logic                   overflow,
    output logic                   symb_tick
);

    localparam int STEP_W = $clog2(STEPS_PER_SYMBOL);
    localparam int DUTY_W = $clog2(STEPS_PER_SYMBOL + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_SYMBOL - 1);

    state_e                 state_q,     state_d;
    logic                   sync1_q,     sync1_d;
    logic                   pwm_s_q,     pwm_s_d;
    logic                   pwm_prev_q,  pwm_prev_d;
    logic [STEP_W-1:0]      step_q,      step_d;
    logic [DUTY_W-1:0]      duty_q,      duty_d;
    logic                   write_q,     write_d;
    logic [SAMPLE_BITS-1:0] sample_q,    sample_d;
    logic                   locked_q,    locked_d;
    logic                   overflow_q,  overflow_d;
    logic                   symb_tick_q, symb_tick_d;

    logic              step_tick;
    logic              pwm_rise;
    logic              sym_end;
    logic [DUTY_W-1:0] duty_cnt;

    // Symbol end always lands on a tick, and a tick reloads the timer, so the
    // next window's first tick is exactly CLKS_PER_STEP later with no gap.
    pwm_demodulator_counter #(
        .WIDTH     (8),
        .MAX_COUNT (CLKS_PER_STEP)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != ST_MEASURE),
        .tick (step_tick)
    );

    assign pwm_rise = pwm_s_q & ~pwm_prev_q;
    assign sym_end  = step_tick && (step_q == LAST_STEP);

    // Each tick counts the level pwm_s had one cycle earlier, so the window
    // starts on the very cycle the lock edge was seen and covers exactly
    // STEPS_PER_SYMBOL steps of the line from there.
    assign duty_cnt = duty_q + DUTY_W'(pwm_prev_q);

    always_comb begin
        sync1_d     = pwm_in;
        pwm_s_d     = sync1_q;
        pwm_prev_d  = pwm_s_q;
        state_d     = state_q;
        step_d      = step_q;
        duty_d      = duty_q;
        write_d     = 1'b0;
        sample_d    = sample_q;
        overflow_d  = overflow_q;
        symb_tick_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (pwm_rise) begin
                    state_d = ST_MEASURE;
                    step_d  = '0;
                    duty_d  = '0;
                end
            end
            ST_MEASURE: begin
                if (sym_end) begin
                    step_d      = '0;
                    duty_d      = '0;
                    symb_tick_d = 1'b1;
                    sample_d    = SAMPLE_BITS'(sat_limit(int'(duty_cnt), SAMPLE_BITS));
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        write_d = 1'b1;
                    end
                end else if (step_tick) begin
                    step_d = step_q + STEP_W'(1);
                    duty_d = duty_cnt;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable wins over everything, including a coincident symbol end.
        if (!enable) begin
            state_d     = ST_IDLE;
            step_d      = '0;
            duty_d      = '0;
            write_d     = 1'b0;
            symb_tick_d = 1'b0;
            sample_d    = sample_q;
            overflow_d  = overflow_q;
        end

        locked_d = (state_d == ST_MEASURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            pwm_s_q     <= 1'b0;
            pwm_prev_q  <= 1'b0;
            step_q      <= '0;
            duty_q      <= '0;
            write_q     <= 1'b0;
            sample_q    <= '0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
            symb_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            pwm_s_q     <= pwm_s_d;
            pwm_prev_q  <= pwm_prev_d;
            step_q      <= step_d;
            duty_q      <= duty_d;
            write_q     <= write_d;
            sample_q    <= sample_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
            symb_tick_q <= symb_tick_d;
        end
    end

    assign write     = write_q;
    assign sample    = sample_q;
    assign locked    = locked_q;
    assign overflow  = overflow_q;
    assign symb_tick = symb_tick_q;

endmodule

// File: doc/pwm_demodulator.md
PWM_DEMODULATOR -- requirements
Module: pwm_demodulator

Interface
REQ-001 SHALL have parameter CLKS_PER_STEP, default 1, giving clk cycles per PWM step (range 1..255).
REQ-002 SHALL have parameter STEPS_PER_SYMBOL, default 128, giving PWM steps per symbol window (range 2..512).
REQ-003 SHALL have parameter SAMPLE_BITS, default 8, giving the recovered sample width.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1 bit: run; low aborts the current symbol.
REQ-007 SHALL have port pwm_in, input, 1 bit: asynchronous PWM line.
REQ-008 SHALL have port full, input, 1 bit: downstream FIFO full.
REQ-009 SHALL have port write, output, 1 bit: one-cycle FIFO write strobe.
REQ-010 SHALL have port sample, output, SAMPLE_BITS: recovered duty value, valid while write is high.
REQ-011 SHALL have port locked, output, 1 bit: high in MEASURE.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a sample dropped on full.
REQ-013 SHALL have port symb_tick, output, 1 bit: one-cycle pulse at each symbol end.

Function
REQ-014 SHALL pass pwm_in through a 2-flop synchronizer (pwm_s); rising-edge detect on pwm_s; input-to-edge latency 3 clk.
REQ-015 SHALL implement the FSM states IDLE, ACQUIRE and MEASURE.
REQ-016 SHALL, in IDLE, go to ACQUIRE when enable=1.
REQ-017 SHALL, in ACQUIRE, go to MEASURE on the first rising edge of pwm_s; in that cycle clear step and clock counters and duty count to 0.
REQ-018 SHALL, in MEASURE, assert a step tick on the entry cycle and then every CLKS_PER_STEP clk.
REQ-019 SHALL, on each step tick, increment the duty count by 1 when pwm_s=1 (duty count width ceil(log2(STEPS_PER_SYMBOL+1))).
REQ-020 SHALL treat the STEPS_PER_SYMBOL-th tick as symbol end: count that tick's step first, then pulse symb_tick, then register sample = min(duty, 2^SAMPLE_BITS-1) with saturation and never wrap.
REQ-021 SHALL, at symbol end, pulse write for 1 clk if full=0; if full=1, drop the sample, keep write=0, set overflow=1.
REQ-022 SHALL, at symbol end, restart the window with no gap: duty restarts from 0 and the next tick is exactly CLKS_PER_STEP later; FSM stays in MEASURE (free-running, no re-sync).
REQ-023 SHALL ignore rising edges of pwm_s during MEASURE.
REQ-024 SHALL, when enable=0 in any state, go to IDLE next cycle, discard the partial symbol, keep write=0, leave overflow unchanged.
REQ-025 SHALL let enable=0 win over a symbol end in the same cycle: no write.
REQ-026 SHALL have write=0 at all times outside a symbol-end cycle.
REQ-027 SHALL sample full only in the symbol-end cycle.
REQ-028 SHALL clear overflow only by rst.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, set state IDLE, synchronizer flops 0, counters 0, write 0, sample 0, locked 0, overflow 0, symb_tick 0.
REQ-030 SHALL let rst mid-symbol abort without any write; after rst deasserts, reacquisition starts from the next rising edge.

Structure
REQ-031 SHALL place FSM state encodings and default step/symbol constants in project_defines.v, shared with the transmit-side modulator.
REQ-032 SHALL generate the step tick with one sub-module, module_counter (WIDTH 8, max_count CLKS_PER_STEP), reset by rst or MEASURE entry or symbol end.
REQ-033 SHALL keep the symbol step counter and the duty counter inline.

Verification
REQ-034 SHALL verify half duty: CLKS_PER_STEP=1, STEPS=128, PWM high 64 of 128 clk, repeated -> write every 128 clk, sample=64 from the 1st full symbol.
REQ-035 SHALL verify saturation: STEPS=256, pwm_in held high after one rising edge -> sample=255 each symbol.
REQ-036 SHALL verify zero duty after lock: lock on a symbol of duty 10, then pwm_in held low -> samples 10, 0, 0, and locked stays 1.
REQ-037 SHALL verify full handling: full=1 during the 2nd symbol end -> no write on that symbol, overflow=1 and stays set, 3rd symbol written normally.
REQ-038 SHALL verify slow steps: CLKS_PER_STEP=4, duty 30/128 -> sample=30, symb_tick period 512 clk.
REQ-039 SHALL verify aborts: rst pulse and, separately, enable=0 at step 70 of a symbol -> no write, locked=0, next sample taken only after a new rising edge.
